// File: rtl/fft_butterfly_scheduler_if.sv
// Control/address bundle between the FFT butterfly scheduler
// and the sample memory / butterfly datapath it sequences.
interface fft_butterfly_scheduler_if #(
  parameter int LOG2_N = 4
);
  logic              i_start;
  logic              o_busy;
  logic              o_done;
  logic [LOG2_N-1:0] o_stage;
  logic              o_rd_en;
  logic [LOG2_N-1:0] o_rd_addr_A;
  logic [LOG2_N-1:0] o_rd_addr_B;
  logic [LOG2_N-2:0] o_tw_idx;
  logic              o_wr_en;
  logic [LOG2_N-1:0] o_wr_addr_A;
  logic [LOG2_N-1:0] o_wr_addr_B;

  modport master (
    input  i_start,
    output o_busy, o_done, o_stage,
    output o_rd_en, o_rd_addr_A, o_rd_addr_B, o_tw_idx,
    output o_wr_en, o_wr_addr_A, o_wr_addr_B
  );

  modport slave (
    output i_start,
    input  o_busy, o_done, o_stage,
    input  o_rd_en, o_rd_addr_A, o_rd_addr_B, o_tw_idx,
    input  o_wr_en, o_wr_addr_A, o_wr_addr_B
  );
endinterface

// File: rtl/fft_butterfly_scheduler.sv
// Radix-2 in-place FFT butterfly scheduler: issues one A/B read
// pair per cycle per stage, and replays them as delayed writes.
module fft_butterfly_scheduler #(
  parameter int LOG2_N       = 4,
  parameter int BFLY_LATENCY = 2
) (
  input logic i_CLK,
  input logic i_RST,
  fft_butterfly_scheduler_if.master bus
);
  localparam int KW = LOG2_N - 1;
  localparam int N  = 1 << LOG2_N;
  localparam int D  = 1 + BFLY_LATENCY;
  localparam int DW = $clog2(D + 1);

  localparam logic [LOG2_N-1:0] S_LAST = LOG2_N'(LOG2_N - 1);
  localparam logic [KW-1:0]     K_LAST = KW'(N / 2 - 1);
  localparam logic [DW-1:0]     D_LAST = DW'(D - 1);
  localparam logic [KW-1:0]     K_ONES = '1;
  localparam logic [LOG2_N-1:0] ONE    = LOG2_N'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LOG2_N-1:0] s_q, s_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;

  logic              rd_en;
  logic [KW-1:0]     pk;
  logic [LOG2_N-1:0] kx, j, a, b;
  logic [KW-1:0]     tw;

  logic [D-1:0]             pipe_en;
  logic [D-1:0][LOG2_N-1:0] pipe_a;
  logic [D-1:0][LOG2_N-1:0] pipe_b;

  // FSM and stage/index counters
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // next-state logic and status outputs
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    k_d        = k_q;
    dcnt_d     = dcnt_q;
    bus.o_busy = 1'b0;
    bus.o_done = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = ISSUE;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        bus.o_busy = 1'b1;
        rd_en      = 1'b1;
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        bus.o_busy = 1'b1;
        if (dcnt_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
            s_d     = '0;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      DONE: begin
        bus.o_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // pair addressing: p = k mod 2^s, j = k div 2^s
  always_comb begin
    pk = k_q & ~(K_ONES << s_q);
    kx = {1'b0, k_q};
    j  = kx >> s_q;
    a  = ((j << 1) << s_q) | {1'b0, pk};
    b  = a | (ONE << s_q);
    tw = pk << (S_LAST - s_q);
  end

  // read side, zeroed whenever no pair is issued
  always_comb begin
    bus.o_stage     = s_q;
    bus.o_rd_en     = rd_en;
    bus.o_rd_addr_A = rd_en ? a : '0;
    bus.o_rd_addr_B = rd_en ? b : '0;
    bus.o_tw_idx    = rd_en ? tw : '0;
  end

  // write-back delay line: memory read plus butterfly latency
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pipe_en <= '0;
      pipe_a  <= '0;
      pipe_b  <= '0;
    end else begin
      pipe_en[0] <= bus.o_rd_en;
      pipe_a[0]  <= bus.o_rd_addr_A;
      pipe_b[0]  <= bus.o_rd_addr_B;
      for (int i = 1; i < D; i++) begin
        pipe_en[i] <= pipe_en[i-1];
        pipe_a[i]  <= pipe_a[i-1];
        pipe_b[i]  <= pipe_b[i-1];
      end
    end
  end

  // write side taken from the tail of the delay line
  always_comb begin
    bus.o_wr_en     = pipe_en[D-1];
    bus.o_wr_addr_A = pipe_a[D-1];
    bus.o_wr_addr_B = pipe_b[D-1];
  end
endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Directed bench for fft_butterfly_scheduler, N=16, latency 2.
// Cycle 1 is the first cycle with o_busy high.
module tb_fft_butterfly_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  fft_butterfly_scheduler_if #(.LOG2_N(4)) bus ();

  fft_butterfly_scheduler #(
    .LOG2_N(4),
    .BFLY_LATENCY(2)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] outs();
    return {5'b0, bus.o_busy, bus.o_done, bus.o_stage,
            bus.o_rd_en, bus.o_rd_addr_A, bus.o_rd_addr_B,
            bus.o_tw_idx, bus.o_wr_en, bus.o_wr_addr_A,
            bus.o_wr_addr_B};
  endfunction

  // each stage: 8 issue cycles starting at 1+11*t, writes 3 later
  function automatic logic exp_rd(input int c);
    for (int t = 0; t < 4; t++)
      if (c >= 1 + 11 * t && c <= 8 + 11 * t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_wr(input int c);
    for (int t = 0; t < 4; t++)
      if (c >= 4 + 11 * t && c <= 11 + 11 * t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_cycle(input int c);
    check($sformatf("busy c%0d", c), 32'(bus.o_busy),
          32'(c >= 1 && c <= 44));
    check($sformatf("done c%0d", c), 32'(bus.o_done),
          32'(c == 45));
    check($sformatf("rd_en c%0d", c), 32'(bus.o_rd_en),
          32'(exp_rd(c)));
    check($sformatf("wr_en c%0d", c), 32'(bus.o_wr_en),
          32'(exp_wr(c)));
    if (c >= 1 && c <= 44)
      check($sformatf("stage c%0d", c), 32'(bus.o_stage),
            32'((c - 1) / 11));
  endtask

  task automatic check_rd(input string tag, input int a,
                          input int b, input int tw);
    check({tag, " A"}, 32'(bus.o_rd_addr_A), 32'(a));
    check({tag, " B"}, 32'(bus.o_rd_addr_B), 32'(b));
    check({tag, " tw"}, 32'(bus.o_tw_idx), 32'(tw));
  endtask

  task automatic check_wr(input string tag, input int a,
                          input int b);
    check({tag, " wA"}, 32'(bus.o_wr_addr_A), 32'(a));
    check({tag, " wB"}, 32'(bus.o_wr_addr_B), 32'(b));
  endtask

  initial begin
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outs", outs(), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle outs", outs(), 32'h0);

    // single start pulse, full run
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      check_cycle(c);
      if (c == 1) check_rd("s0k0", 0, 1, 0);
      if (c == 2) check_rd("s0k1", 2, 3, 0);
      if (c == 13) check_rd("s1k1", 1, 3, 4);
      if (c == 28) check_rd("s2k5", 9, 13, 2);
      if (c == 41) check_rd("s3k7", 7, 15, 7);
      if (c == 4) check_wr("wr s0k0", 0, 1);
      if (c == 16) check_wr("wr s1k1", 1, 3);
      if (c == 31) check_wr("wr s2k5", 9, 13);
      if (c == 44) check_wr("wr s3k7", 7, 15);
      @(negedge clk);
    end

    // start held high through the run, dropped after o_done
    bus.i_start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 46; c++) begin
      check_cycle(c);
      if (c == 45) bus.i_start = 1'b0;
      @(negedge clk);
    end

    // fresh run, then reset in cycle 17
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      check_cycle(c);
      if (c == 1) check_rd("rerun s0k0", 0, 1, 0);
      if (c == 17) rst = 1'b1;
      @(negedge clk);
    end
    for (int c = 18; c <= 50; c++) begin
      check($sformatf("post-rst outs c%0d", c), outs(), 32'h0);
      if (c == 18) rst = 1'b0;
      @(negedge clk);
    end

    // reset and start together
    rst = 1'b1;
    bus.i_start = 1'b1;
    @(negedge clk);
    check("rst+start busy", 32'(bus.o_busy), 32'h0);
    check("rst+start outs", outs(), 32'h0);
    rst = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clk);
    check("rst+start idle", outs(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_butterfly_scheduler.md
FFT_BUTTERFLY_SCHEDULER -- requirements
Module: fft_butterfly_scheduler

Interface
REQ-001 SHALL have parameter LOG2_N, default 4, meaning log2 of FFT point count N (N = 2^LOG2_N, LOG2_N >= 2).
REQ-002 SHALL have parameter BFLY_LATENCY, default 2, meaning clock cycles from butterfly input to butterfly output.
REQ-003 SHALL have port i_CLK  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_RST  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  meaning request to run one complete in-place FFT.
REQ-006 SHALL have port o_busy  output  1  meaning a transform is in progress.
REQ-007 SHALL have port o_done  output  1  meaning one-cycle pulse at transform completion.
REQ-008 SHALL have port o_stage  output  LOG2_N  meaning current stage index s.
REQ-009 SHALL have port o_rd_en  output  1  meaning read the A/B pair this cycle.
REQ-010 SHALL have ports o_rd_addr_A and o_rd_addr_B  output  LOG2_N each  meaning sample-memory read addresses.
REQ-011 SHALL have port o_tw_idx  output  LOG2_N-1  meaning twiddle-ROM index for the issued pair.
REQ-012 SHALL have port o_wr_en  output  1  meaning write the butterfly outputs this cycle.
REQ-013 SHALL have ports o_wr_addr_A and o_wr_addr_B  output  LOG2_N each  meaning write-back addresses for o_A and o_B.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-015 SHALL, in IDLE with i_start=1, move to ISSUE with s=0 and k=0 and assert o_busy from the next cycle.
REQ-016 SHALL ignore i_start in every state except IDLE.
REQ-017 SHALL, in ISSUE, assert o_rd_en every cycle and advance butterfly index k from 0 to N/2-1, one per cycle.
REQ-018 SHALL compute addresses with half = 2^s, p = k mod half, j = k div half.
REQ-019 SHALL drive o_rd_addr_A = 2*half*j + p.
REQ-020 SHALL drive o_rd_addr_B = o_rd_addr_A + half.
REQ-021 SHALL drive o_tw_idx = p shifted left by (LOG2_N-1-s).
REQ-022 SHALL compute all addresses in unsigned arithmetic with no overflow for any legal s and k.
REQ-023 SHALL move from ISSUE to DRAIN after issuing k = N/2-1.
REQ-024 SHALL keep DRAIN for exactly 1+BFLY_LATENCY cycles, accounting for 1 cycle of memory read latency, so that no read of stage s+1 precedes the last write of stage s.
REQ-025 SHALL, at the end of DRAIN, move to ISSUE with s+1 and k=0 if s < LOG2_N-1, otherwise move to DONE.
REQ-026 SHALL give o_wr_en, o_wr_addr_A and o_wr_addr_B as copies of o_rd_en, o_rd_addr_A and o_rd_addr_B delayed by exactly 1+BFLY_LATENCY cycles through a shift pipeline.
REQ-027 SHALL make each stage last N/2 + 1 + BFLY_LATENCY cycles, with total busy time LOG2_N*(N/2+1+BFLY_LATENCY) cycles.
REQ-028 SHALL, in DONE, pulse o_done for one cycle, deassert o_busy in the same cycle, and return to IDLE.
REQ-029 SHALL drive o_rd_en=0 and o_wr_en=0 whenever no valid pair is present; address outputs are don't-care when their enable is 0.

Reset
REQ-030 SHALL, when i_RST=1 at a clock edge in any state, go to IDLE, clear s, k and the write-delay pipeline, and drive all outputs to 0 the next cycle.
REQ-031 SHALL, on reset mid-transform, issue no write for pairs in flight and produce no o_done pulse.
REQ-032 SHALL give reset priority over a simultaneous i_start.

Verification (LOG2_N=4, BFLY_LATENCY=2; cycle 1 = first cycle with o_busy=1)
REQ-033 SHALL show that a single i_start pulse gives o_rd_en=1 in cycles 1-8, 12-19, 23-30 and 34-41, o_wr_en=1 in cycles 4-11, 15-22, 26-33 and 37-44, o_done=1 in cycle 45 only, and o_busy=0 from cycle 45.
REQ-034 SHALL show address triplets (A, B, tw): stage 0, k=0 gives (0, 1, 0); stage 1, k=1 gives (1, 3, 4); stage 2, k=5 gives (9, 13, 2); stage 3, k=7 gives (7, 15, 7).
REQ-035 SHALL show that each write address equals the read address from 3 cycles earlier, e.g. write (7, 15) in cycle 44.
REQ-036 SHALL show that i_start held high through a run and again at cycle 20 starts no second transform, and that after o_done a new i_start begins a fresh run at stage 0.
REQ-037 SHALL show that i_RST asserted at cycle 17 gives all outputs 0 from cycle 18, no o_wr_en afterward, and no o_done.
REQ-038 SHALL show that i_RST and i_start asserted in the same cycle leave the block in IDLE with o_busy=0.
